// File: rtl/controller_mc.sv
// controller_mc: multicycle RISC-V control unit.
// A Moore FSM sequences fetch, decode, address generation, execute and
// writeback so a single ALU and a unified memory can be shared. Only the
// FETCH enables (gated by MemReady) and the BRANCH PC write (from the ALU
// flags) depend combinationally on inputs. While reset is low every
// enable is held at 0.
module controller_mc #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_UNSIGNED   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Menor,
  input  logic       MenorU,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  state_t     state;
  state_t     state_next;
  logic       ready;
  logic       branch_ok;
  logic       taken;
  logic [3:0] alu_dec;

  // Memory access completes this cycle (always true without handshake)
  assign ready = MemReady | ~MEM_HANDSHAKE;

  // Branch funct3 010/011 are reserved; 110/111 need unsigned support
  assign branch_ok = (funct3[2:1] != 2'b01) &&
                     (EN_UNSIGNED || (funct3[2:1] != 2'b11));

  assign State = STATE_W'(state);

  // State register with asynchronous clear to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = branch_ok ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (ready) state_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // ALU operation for R/I execute; sub only exists in the R form
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  // Branch condition from the ALU comparison flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Menor;
      3'b101:  taken = ~Menor;
      3'b110:  taken = MenorU;
      3'b111:  taken = ~MenorU;
      default: taken = 1'b0;
    endcase
  end

  // Immediate format selected directly from the opcode
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Per-state datapath controls, with enables suppressed during reset
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      S_TRAP:   IllegalOp = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_mc.sv
// tb_controller_mc: checks controller_mc against an instruction-level model.
// Instance a has handshake and unsigned branches enabled, instance b has
// both disabled; they share all inputs.
module tb_controller_mc;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal_op;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, menor, menoru, mem_ready;

  logic       a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write;
  logic       a_reg_write, a_illegal_op;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
  logic [3:0] a_alu_control, a_state;
  logic [2:0] a_imm_src;
  logic       b_pc_write, b_adr_src, b_mem_read, b_mem_write, b_ir_write;
  logic       b_reg_write, b_illegal_op;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
  logic [3:0] b_alu_control, b_state;
  logic [2:0] b_imm_src;

  ctl_t obs_a, obs_b;

  int vectors     = 0;
  int miscompares = 0;

  int         m_state [2];
  int         m_pos   [2];
  logic [19:0] m_plan [2];

  int         lw_seq [6] = '{0, 1, 2, 3, 4, 0};
  logic [3:0] alu_by_f3 [8] = '{4'h0, 4'h6, 4'h5, 4'h9, 4'h4, 4'h7, 4'h3, 4'h2};
  logic [10:0] alu_tab [12] = '{
    {7'b0110011, 3'b000, 1'b0}, {7'b0110011, 3'b001, 1'b0},
    {7'b0110011, 3'b010, 1'b0}, {7'b0110011, 3'b011, 1'b0},
    {7'b0110011, 3'b100, 1'b0}, {7'b0110011, 3'b101, 1'b0},
    {7'b0110011, 3'b101, 1'b1}, {7'b0110011, 3'b110, 1'b0},
    {7'b0110011, 3'b111, 1'b0}, {7'b0010011, 3'b000, 1'b1},
    {7'b0010011, 3'b101, 1'b0}, {7'b0010011, 3'b011, 1'b1}
  };
  logic [2:0] flag_tab [4] = '{3'b000, 3'b111, 3'b010, 3'b101};

  int wr_a, wr_b;

  controller_mc #(.MEM_HANDSHAKE(1'b1), .EN_UNSIGNED(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .Menor(menor), .MenorU(menoru), .MemReady(mem_ready),
    .PCWrite(a_pc_write), .AdrSrc(a_adr_src), .MemRead(a_mem_read),
    .MemWrite(a_mem_write), .IRWrite(a_ir_write), .ResultSrc(a_result_src),
    .ALUSrcA(a_alu_src_a), .ALUSrcB(a_alu_src_b), .ALUControl(a_alu_control),
    .ImmSrc(a_imm_src), .RegWrite(a_reg_write), .IllegalOp(a_illegal_op),
    .State(a_state)
  );

  controller_mc #(.MEM_HANDSHAKE(1'b0), .EN_UNSIGNED(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .Menor(menor), .MenorU(menoru), .MemReady(mem_ready),
    .PCWrite(b_pc_write), .AdrSrc(b_adr_src), .MemRead(b_mem_read),
    .MemWrite(b_mem_write), .IRWrite(b_ir_write), .ResultSrc(b_result_src),
    .ALUSrcA(b_alu_src_a), .ALUSrcB(b_alu_src_b), .ALUControl(b_alu_control),
    .ImmSrc(b_imm_src), .RegWrite(b_reg_write), .IllegalOp(b_illegal_op),
    .State(b_state)
  );

  assign obs_a = {a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write,
                  a_reg_write, a_illegal_op, a_result_src, a_alu_src_a,
                  a_alu_src_b, a_alu_control, a_imm_src, a_state};
  assign obs_b = {b_pc_write, b_adr_src, b_mem_read, b_mem_write, b_ir_write,
                  b_reg_write, b_illegal_op, b_result_src, b_alu_src_a,
                  b_alu_src_b, b_alu_control, b_imm_src, b_state};

  always #5 clk = ~clk;

  // Whole-instruction step list: {length, s3, s2, s1, s0} in nibbles
  function automatic logic [19:0] plan_of(input logic [6:0] o, input logic [2:0] f3,
                                          input bit en_u);
    case (o)
      7'b0000011: return 20'h44321;
      7'b0100011: return 20'h30521;
      7'b0110011: return 20'h30861;
      7'b0010011: return 20'h30871;
      7'b1101111: return 20'h30891;
      7'b0110111: return 20'h308B1;
      7'b1100011:
        if (f3 == 3'b010 || f3 == 3'b011 || (!en_u && f3[2:1] == 2'b11))
          return 20'h200C1;
        else
          return 20'h200A1;
      default:    return 20'h200C1;
    endcase
  endfunction

  function automatic bit rdy_of(input int k);
    return (k == 0) ? mem_ready : 1'b1;
  endfunction

  function automatic logic [3:0] alu_of(input bit rtype);
    if (funct3 == 3'b101 && funct7b5) return 4'h8;
    if (rtype && funct3 == 3'b000 && funct7b5) return 4'h1;
    return alu_by_f3[funct3];
  endfunction

  function automatic bit taken_of();
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return menor;
      3'b101:  return !menor;
      3'b110:  return menoru;
      3'b111:  return !menoru;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic ctl_t expect_of(input int s, input int k);
    ctl_t e;
    e = '0;
    e.state   = 4'(s);
    e.imm_src = imm_of(op);
    case (s)
      0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.ir_write = rdy_of(k); e.pc_write = rdy_of(k); end
      1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
      2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      3:  begin e.mem_read = 1'b1; e.adr_src = 1'b1; end
      4:  begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      5:  begin e.mem_write = 1'b1; e.adr_src = 1'b1; end
      6:  begin e.alu_src_a = 2'b10; e.alu_control = alu_of(1'b1); end
      7:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = alu_of(1'b0); end
      8:  e.reg_write = 1'b1;
      9:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      10: begin e.alu_src_a = 2'b10; e.alu_control = 4'h1; e.pc_write = taken_of(); end
      11: begin e.alu_src_a = 2'b11; e.alu_src_b = 2'b01; end
      12: e.illegal_op = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_read = 1'b0;
      e.mem_write = 1'b0; e.reg_write = 1'b0; e.illegal_op = 1'b0;
    end
    return e;
  endfunction

  // Model: walk the planned steps, stalling memory steps until ready
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_state[k] <= 0;
        m_pos[k]   <= 0;
      end else if (m_state[k] == 0) begin
        if (rdy_of(k)) begin
          m_plan[k]  <= plan_of(op, funct3, k == 0);
          m_pos[k]   <= 0;
          m_state[k] <= 1;
        end
      end else if (m_state[k] != 12 &&
                   (!(m_state[k] == 3 || m_state[k] == 5) || rdy_of(k))) begin
        if (m_pos[k] + 1 < int'(m_plan[k][19:16])) begin
          m_pos[k]   <= m_pos[k] + 1;
          m_state[k] <= int'(m_plan[k][4*(m_pos[k]+1) +: 4]);
        end else begin
          m_state[k] <= 0;
        end
      end
    end
  end

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      ctl_t e, o;
      e = expect_of(m_state[k], k);
      o = (k == 0) ? obs_a : obs_b;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL model_%0d t=%0t got=%h exp=%h", k, $time, o, e);
      end
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sample();
    step();
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      step();
    end
  endtask

  // Asserts reset between clock edges and checks the immediate return to FETCH
  task automatic mid_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    lit({name, "_state_a"}, int'(a_state), 0);
    lit({name, "_state_b"}, int'(b_state), 0);
    lit({name, "_enables_a"}, int'({a_pc_write, a_ir_write, a_mem_read, a_mem_write,
                                    a_reg_write, a_illegal_op}), 0);
    model_check();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; menor = 1'b0; menoru = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);

    // lw: reset values, then 0,1,2,3,4,0
    reset = 1'b0;
    sample();
    lit("rst_state", int'(a_state), 0);
    lit("rst_memread", int'(a_mem_read), 0);
    lit("rst_irwrite", int'(a_ir_write), 0);
    lit("rst_alusrcb", int'(a_alu_src_b), 2);
    lit("rst_resultsrc", int'(a_result_src), 2);
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      lit("lw_state", int'(a_state), lw_seq[i]);
      lit("lw_regwrite", int'(a_reg_write), int'(i == 4));
      if (i == 4) lit("lw_resultsrc", int'(a_result_src), 1);
      step();
    end

    // R-type sub and srai
    set_instr(7'b0110011, 3'b000, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 2) lit("sub_aluctl", int'(a_alu_control), 1);
      if (i == 4) lit("r_len", int'(a_state), 0);
      step();
    end
    set_instr(7'b0010011, 3'b101, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 2) lit("srai_aluctl", int'(a_alu_control), 8);
      if (i == 2) lit("srai_state", int'(a_state), 7);
      step();
    end

    // Remaining ALU encodings
    for (int j = 0; j < 12; j++) begin
      set_instr(alu_tab[j][10:4], alu_tab[j][3:1], alu_tab[j][0]);
      do_reset();
      run(5);
    end

    // bne not-equal: taken, 3 cycles
    set_instr(7'b1100011, 3'b001, 1'b0);
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 2) lit("bne_pcwrite_a", int'(a_pc_write), 1);
      if (i == 2) lit("bne_pcwrite_b", int'(b_pc_write), 1);
      if (i == 3) lit("bne_len", int'(a_state), 0);
      step();
    end

    // bgeu with rs1 < rs2: not taken; traps without unsigned support
    set_instr(7'b1100011, 3'b111, 1'b0);
    menoru = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 2) lit("bgeu_pcwrite_a", int'(a_pc_write), 0);
      if (i == 2) lit("bgeu_trap_b", int'(b_state), 12);
      step();
    end

    // bltu: taken on a, sticky trap on b until reset
    set_instr(7'b1100011, 3'b110, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample();
      if (i == 2) lit("bltu_pcwrite_a", int'(a_pc_write), 1);
      if (i >= 2) lit("bltu_illegal_b", int'(b_illegal_op), 1);
      step();
    end
    mid_reset("bltu_rst");
    lit("bltu_rst_illegal_b", int'(b_illegal_op), 0);

    // Every branch funct3 against several flag patterns
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 4; p++) begin
        set_instr(7'b1100011, 3'(f), 1'b0);
        {zero, menor, menoru} = flag_tab[p];
        do_reset();
        run(4);
      end
    end
    zero = 1'b0; menor = 1'b0; menoru = 1'b0;

    // sw with three wait cycles in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    do_reset();
    wr_a = 0;
    wr_b = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      sample();
      if (i < 7) begin
        wr_a += int'(a_mem_write);
        wr_b += int'(b_mem_write);
      end
      if (i == 7) lit("sw_done_state", int'(a_state), 0);
      step();
    end
    lit("sw_wait_memwrite_cycles", wr_a, 4);
    lit("sw_nohs_memwrite_cycles", wr_b, 1);
    mem_ready = 1'b1;

    // lw with waits in FETCH and MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = (i <= 1 || i == 5) ? 1'b0 : 1'b1;
      sample();
      if (i == 0) lit("fetch_wait_irwrite_a", int'(a_ir_write), 0);
      if (i == 0) lit("fetch_nohs_irwrite_b", int'(b_ir_write), 1);
      if (i == 5) lit("memread_wait_state", int'(a_state), 3);
      if (i == 7) lit("memwb_state", int'(a_state), 4);
      if (i == 8) lit("lw_wait_done", int'(a_state), 0);
      step();
    end
    mem_ready = 1'b1;

    // Illegal opcode: DECODE then TRAP, then asynchronous reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 1) lit("ill_decode", int'(a_state), 1);
      if (i >= 2) lit("ill_trap", int'(a_state), 12);
      if (i >= 2) lit("ill_flag", int'(a_illegal_op), 1);
      if (i >= 2) lit("ill_enables", int'({a_pc_write, a_ir_write, a_mem_read,
                                           a_mem_write, a_reg_write}), 0);
      step();
    end
    mid_reset("ill_rst");

    // jal then lui back to back
    set_instr(7'b1101111, 3'b000, 1'b0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) set_instr(7'b0110111, 3'b000, 1'b0);
      sample();
      if (i == 2) lit("jal_state", int'(a_state), 9);
      if (i == 2) lit("jal_pcwrite", int'(a_pc_write), 1);
      if (i == 2) lit("jal_resultsrc", int'(a_result_src), 0);
      if (i == 4) lit("jal_len", int'(a_state), 0);
      if (i == 6) lit("lui_state", int'(a_state), 11);
      if (i == 6) lit("lui_srca", int'(a_alu_src_a), 3);
      if (i == 6) lit("lui_immsrc", int'(a_imm_src), 4);
      if (i == 7) lit("lui_regwrite", int'(a_reg_write), 1);
      if (i == 8) lit("lui_len", int'(a_state), 0);
      step();
    end

    // Reset mid-instruction aborts it
    set_instr(7'b0110011, 3'b000, 1'b0);
    do_reset();
    run(2);
    sample();
    lit("abort_pre_state", int'(a_state), 6);
    mid_reset("abort");
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controller_mc.md
# controller_mc

Multicycle control unit for the RISC-V core, successor to the single-cycle controller. A Moore-style FSM sequences each instruction over 3–5+ cycles so one shared ALU and one unified memory serve fetch, address generation and execution. It adds a ready/request memory handshake, the unsigned branches (bltu/bgeu) and an illegal-opcode trap state. It sits between the instruction register / ALU flags and the multicycle datapath.

## Interface
- MEM_HANDSHAKE, 1, 1: memory states wait for MemReady; 0: MemReady ignored, every access completes in one cycle
- EN_UNSIGNED, 1, 1: bltu/bgeu legal; 0: funct3 110/111 on branches traps

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode (from instruction register)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result == 0
- Menor  in  1  signed rs1 < rs2
- MenorU  in  1  unsigned rs1 < rs2
- MemReady  in  1  memory access complete this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0: address = PC, 1: address = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
- RegWrite  out  1  register file write enable
- IllegalOp  out  1  high while in TRAP
- State  out  4  current state encoding (debug)

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BRANCH 10, LUI 11, TRAP 12. Codes 13–15 return to FETCH on the next clock.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=MemReady (forced to 1 when MEM_HANDSHAKE=0). Advance to DECODE only on MemReady; otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - any other → TRAP
  - If EN_UNSIGNED=0 and op=1100011 with funct3[2:1]=11 → TRAP
  - Branch funct3 010/011 → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op[5]=0 → MEMREAD, else → MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1, ResultSrc=00. Hold until MemReady, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1, ResultSrc=00. Hold until MemReady, then → FETCH.
- EXECR / EXECI: ALUSrcA=10, ALUSrcB=00/01, ALUControl decoded from funct3 and funct7b5 → ALUWB.
  - sub only for R-type with funct7b5=1.
  - sra when funct3=101 and funct7b5=1 (both R and I).
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, add → ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00 → FETCH.
  - PCWrite=taken, where taken is: 000 Zero, 001 ~Zero, 100 Menor, 101 ~Menor, 110 MenorU, 111 ~MenorU.
- TRAP: all enables 0, IllegalOp=1. Remains in TRAP until reset.
- Outputs not listed for a state are 0 (ALUControl defaults to add).

## Timing
- State register updates on the rising clock edge. Reset clears it to FETCH asynchronously.
- While reset is low: PCWrite, IRWrite, MemRead, MemWrite, RegWrite and IllegalOp are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore from the state, except:
  - FETCH IRWrite/PCWrite gated combinationally by MemReady.
  - BRANCH PCWrite combinational from the flags.
- Cycle counts with zero wait states:
  - beq: 3
  - R, I, jal, lui, sw: 4
  - lw: 5
- Each cycle MemReady stays low in FETCH, MEMREAD or MEMWRITE adds one cycle. Request signals stay asserted and stable throughout the wait.
- Reset asserted mid-instruction aborts it. No write enable may glitch high during the reset assertion.

## Test plan
- Reset low, then high with MemReady=1, lw (op 0000011) → state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, ResultSrc=01.
- R-type sub (op 0110011, funct3 000, funct7b5 1) → ALUControl=0001 in EXECR; srai (op 0010011, funct3 101, funct7b5 1) → 1000.
- Branches: bne with Zero=0 → PCWrite=1; bgeu with MenorU=1 → PCWrite=0; bltu with EN_UNSIGNED=0 → TRAP, IllegalOp=1 held until reset.
- sw with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 cycles, then FETCH. With MEM_HANDSHAKE=0 → exactly 1 cycle.
- op 1111111 → DECODE then TRAP, all enables 0. Assert reset → FETCH immediately, without waiting for a clock edge.
- jal then lui back to back → JAL asserts PCWrite with ResultSrc=00. LUI uses ALUSrcA=11, ImmSrc=100, RegWrite in ALUWB. Each instruction takes 4 cycles.
